// File: rtl/program_loader.sv
// Boot loader: assembles a framed UART byte stream into big-endian words, writes instruction memory,
// and holds the CPU in reset until a valid image is in. Optional trailing checksum: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  imem_address,
  output logic [31:0] imem_data,
  output logic        imem_wren,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [8:0]  word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN = 3'd1, S_DATA = 3'd2, S_CHECK = 3'd3, S_DONE = 3'd4, S_ERROR = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN = 3'd1, S_DATA = 3'd2, S_DONE = 3'd4, S_ERROR = 3'd5
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  wrd_q, wrd_d;     // words received in this frame (wc_q lags by one cycle)
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  wc_q, wc_d;
  logic [31:0] tmo_q, tmo_d;
  logic        cpu_reset_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        hdr;
  logic        timed;
  logic [31:0] tmo_inc;

  assign hdr     = rx_valid && (rx_data == HEADER_BYTE);
  assign tmo_inc = tmo_q + 32'd1;

  always_comb begin
    timed = (state_q == S_LEN) || (state_q == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    timed = timed || (state_q == S_CHECK);
`endif
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wrd_d   = wrd_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wc_d    = wc_q;
    tmo_d   = 32'd0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    // Address/count advance the cycle after the write strobe
    if (wren_q) begin
      addr_d = addr_q + 8'd1;
      wc_d   = wc_q + 9'd1;
    end

    if (timed && !rx_valid) tmo_d = tmo_inc;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (hdr) begin
          state_d = S_LEN;
          addr_d  = 8'd0;
          wc_d    = 9'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          wrd_d   = 9'd0;
          bidx_d  = 2'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          asm_d  = {asm_q[15:0], rx_data};
          bidx_d = bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bidx_q == 2'd3) begin
            data_d = {asm_q, rx_data};
            wren_d = 1'b1;
            wrd_d  = wrd_q + 9'd1;
            if (wrd_q + 9'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A byte in the expiring cycle wins, so only an idle cycle can time out
    if (timed && !rx_valid && (tmo_inc >= TIMEOUT_CYCLES)) state_d = S_ERROR;
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= 9'd0;
      wrd_q       <= 9'd0;
      bidx_q      <= 2'd0;
      asm_q       <= 24'd0;
      data_q      <= 32'd0;
      wren_q      <= 1'b0;
      addr_q      <= 8'd0;
      wc_q        <= 9'd0;
      tmo_q       <= 32'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wrd_q       <= wrd_d;
      bidx_q      <= bidx_d;
      asm_q       <= asm_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wc_q        <= wc_d;
      tmo_q       <= tmo_d;
      cpu_reset_q <= (state_q != S_DONE);
      done_q      <= (state_q == S_DONE);
      err_q       <= (state_q == S_ERROR);
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign imem_address = addr_q;
  assign imem_data    = data_q;
  assign imem_wren    = wren_q;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign word_count   = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; sends the checksum byte only when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  imem_address;
  logic [31:0] imem_data;
  logic        imem_wren;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [8:0]  word_count;

  int errs = 0;
  int checks = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  program_loader #(.TIMEOUT_CYCLES(32'd16), .HEADER_BYTE(8'hA5)) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_address(imem_address), .imem_data(imem_data), .imem_wren(imem_wren),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wren === 1'b1) begin
      wa.push_back(imem_address);
      wd.push_back(imem_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b);
`else
    rx_data = b;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    checks++; if (cpu_reset !== 1'b1) begin errs++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (imem_wren !== 1'b0) begin errs++; $display("FAIL reset_wren got=%b exp=0", imem_wren); end
    checks++; if (imem_address !== 8'h00) begin errs++; $display("FAIL reset_addr got=%h exp=00", imem_address); end
    checks++; if (imem_data !== 32'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", imem_data); end
    checks++; if ({load_done, load_error} !== 2'b00) begin errs++; $display("FAIL reset_flags got=%b exp=00", {load_done, load_error}); end
    checks++; if (word_count !== 9'd0) begin errs++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_garbage;
    wa.delete(); wd.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(2);
    checks++; if (wa.size() != 0) begin errs++; $display("FAIL garbage_writes got=%0d exp=0", wa.size()); end
    checks++; if ({cpu_reset, load_done, load_error} !== 3'b100) begin errs++; $display("FAIL garbage_flags got=%b exp=100", {cpu_reset, load_done, load_error}); end
  endtask

  task automatic test_basic;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if ({imem_wren, imem_address, imem_data} !== {1'b1, 8'h00, 32'h11223344})
      begin errs++; $display("FAIL basic_w0_strobe got=%b/%h/%h exp=1/00/11223344", imem_wren, imem_address, imem_data); end
    send_byte(8'h55);
    checks++; if ({imem_wren, imem_address, word_count} !== {1'b0, 8'h01, 9'd1})
      begin errs++; $display("FAIL basic_w0_after got=%b/%h/%0d exp=0/01/1", imem_wren, imem_address, word_count); end
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_csum(8'h88);
    checks++; if ({cpu_reset, load_done} !== 2'b10) begin errs++; $display("FAIL basic_pre_release got=%b exp=10", {cpu_reset, load_done}); end
    idle(1);
    checks++; if ({cpu_reset, load_done, load_error} !== 3'b010) begin errs++; $display("FAIL basic_release got=%b exp=010", {cpu_reset, load_done, load_error}); end
    idle(1);
    checks++; if (word_count !== 9'd2) begin errs++; $display("FAIL basic_wc got=%0d exp=2", word_count); end
    checks++; if (wa.size() != 2) begin errs++; $display("FAIL basic_nwrites got=%0d exp=2", wa.size()); end
    else begin
      checks++; if ({wa[0], wd[0], wa[1], wd[1]} !== {8'h00, 32'h11223344, 8'h01, 32'h55667788})
        begin errs++; $display("FAIL basic_writes got=%h:%h %h:%h exp=00:11223344 01:55667788", wa[0], wd[0], wa[1], wd[1]); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_error;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(8'h00);
    idle(2);
    checks++; if (wa.size() != 2) begin errs++; $display("FAIL csum_nwrites got=%0d exp=2", wa.size()); end
    checks++; if ({cpu_reset, load_done, load_error} !== 3'b101) begin errs++; $display("FAIL csum_flags got=%b exp=101", {cpu_reset, load_done, load_error}); end
  endtask
`endif

  task automatic test_timeout;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    idle(18);
    checks++; if ({cpu_reset, load_done, load_error} !== 3'b101) begin errs++; $display("FAIL timeout_flags got=%b exp=101", {cpu_reset, load_done, load_error}); end
    checks++; if (wa.size() != 0) begin errs++; $display("FAIL timeout_writes got=%0d exp=0", wa.size()); end
  endtask

  task automatic test_byte_wins;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h01);
    checks++; if (load_error !== 1'b0) begin errs++; $display("FAIL bw_err_clear got=%b exp=0", load_error); end
    idle(15);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    send_csum(8'h30);
    idle(2);
    checks++; if ({cpu_reset, load_done, load_error} !== 3'b010) begin errs++; $display("FAIL bw_flags got=%b exp=010", {cpu_reset, load_done, load_error}); end
    checks++; if (wa.size() != 1) begin errs++; $display("FAIL bw_nwrites got=%0d exp=1", wa.size()); end
    else begin
      checks++; if ({wa[0], wd[0]} !== {8'h00, 32'hCAFEBABE}) begin errs++; $display("FAIL bw_write got=%h:%h exp=00:cafebabe", wa[0], wd[0]); end
    end
  endtask

  task automatic test_len0;
    int bad;
    logic [7:0] v;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      repeat (4) send_byte(v);
    end
    send_csum(8'h00);
    idle(3);
    checks++; if (wa.size() != 256) begin errs++; $display("FAIL len0_nwrites got=%0d exp=256", wa.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        v = 8'(i);
        if (wa[i] !== v || wd[i] !== {v, v, v, v}) bad++;
      end
      checks++; if (bad != 0) begin errs++; $display("FAIL len0_contents got=%0d bad words exp=0", bad); end
      checks++; if ({wa[255], wd[255]} !== {8'hFF, 32'hFFFFFFFF}) begin errs++; $display("FAIL len0_last got=%h:%h exp=ff:ffffffff", wa[255], wd[255]); end
    end
    checks++; if ({word_count, imem_address} !== {9'd256, 8'h00}) begin errs++; $display("FAIL len0_wc_addr got=%0d/%h exp=256/00", word_count, imem_address); end
    checks++; if ({cpu_reset, load_done} !== 2'b01) begin errs++; $display("FAIL len0_flags got=%b exp=01", {cpu_reset, load_done}); end
  endtask

  task automatic test_reset_midframe;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    checks++; if (wa.size() != 0) begin errs++; $display("FAIL rst_mid_writes got=%0d exp=0", wa.size()); end
    checks++; if ({cpu_reset, load_done, word_count} !== {1'b1, 1'b0, 9'd0}) begin errs++; $display("FAIL rst_mid_flags got=%b/%b/%0d exp=1/0/0", cpu_reset, load_done, word_count); end
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    send_csum(8'h30);
    idle(2);
    checks++; if (wa.size() != 1) begin errs++; $display("FAIL rst_mid_nwrites got=%0d exp=1", wa.size()); end
    else begin
      checks++; if ({wa[0], wd[0]} !== {8'h00, 32'hCAFEBABE}) begin errs++; $display("FAIL rst_mid_write got=%h:%h exp=00:cafebabe", wa[0], wd[0]); end
    end
    checks++; if ({cpu_reset, load_done} !== 2'b01) begin errs++; $display("FAIL rst_mid_done got=%b exp=01", {cpu_reset, load_done}); end
  endtask

  task automatic test_reload;
    send_byte(8'hA5);
    checks++; if ({cpu_reset, load_done, word_count} !== {1'b0, 1'b1, 9'd0}) begin errs++; $display("FAIL reload_edge got=%b/%b/%0d exp=0/1/0", cpu_reset, load_done, word_count); end
    idle(1);
    checks++; if ({cpu_reset, load_done} !== 2'b10) begin errs++; $display("FAIL reload_next got=%b exp=10", {cpu_reset, load_done}); end
  endtask

  initial begin
    test_reset();
    test_garbage();
    test_basic();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_error();
`endif
    test_timeout();
    test_byte_wins();
    test_len0();
    test_reset_midframe();
    test_reload();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction-memory writer: receives a framed byte stream from the UART receiver and assembles big-endian 32-bit words. It writes them sequentially into the write port of the 256-word instruction ROM that the CPU fetch path reads. It holds the CPU in reset from power-up until a complete, valid image is loaded, then releases it. It sits between the UART byte receiver and the instruction memory / CPU reset input.

## Interface
Parameters:
- TIMEOUT_CYCLES, 5000000: maximum idle cycles between bytes inside a frame (100 ms at 50 MHz); 32-bit range.
- HEADER_BYTE, 8'hA5: frame start marker.

Ports:
- MAX10_CLK1_50  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
- rx_data  in  8  received byte.
- imem_address  out  8  instruction-memory write address.
- imem_data  out  32  instruction word to write.
- imem_wren  out  1  one-cycle write strobe.
- cpu_reset  out  1  drives the CPU reset; high while no valid image is loaded.
- load_done  out  1  high while a valid image is loaded.
- load_error  out  1  high after a failed frame until the next header.
- word_count  out  9  words written in the current/last frame (0-256).

## Operation
- Frame: HEADER_BYTE, LEN (word count; 0 means 256), LEN×4 data bytes MSB first, then a checksum byte (see Configuration).
- States: IDLE, LEN, DATA, CHECK, DONE, ERROR.
- IDLE: bytes other than HEADER_BYTE are ignored. On HEADER_BYTE -> LEN, clear word_count, imem_address and the checksum accumulator.
- LEN: latch LEN -> DATA.
- DATA: shift the byte into a 32-bit assembler and XOR it into the checksum.
  - On the 4th byte of a word: write the word at imem_address, then increment imem_address (8-bit wrap) and word_count.
  - After word LEN: -> CHECK (or DONE without the macro).
- CHECK: if the received byte equals the accumulator -> DONE, else -> ERROR.
- DONE/ERROR: a HEADER_BYTE starts a new frame (-> LEN). All other bytes are ignored.
- Timeout: an inter-byte counter runs in LEN, DATA and CHECK and clears on each accepted byte. On reaching TIMEOUT_CYCLES -> ERROR.
- No backpressure: every rx_valid byte is consumed in its cycle.

## Timing
- Reset values: cpu_reset=1; imem_wren=0, imem_address=0, imem_data=0, load_done=0, load_error=0, word_count=0; state IDLE.
- imem_wren pulses exactly one cycle, the cycle after the 4th byte of a word is accepted. imem_address and imem_data are stable in that cycle. imem_address increments the following cycle.
- cpu_reset, load_done and load_error are registered. They change the cycle after the state transition.
- cpu_reset falls one cycle after entering DONE. It rises one cycle after a header is accepted in DONE.
- load_error clears one cycle after a header is accepted.
- LEN=0: 256 writes, addresses 0x00-0xFF. imem_address wraps to 0x00 afterwards with no further write.
- A byte arriving in the same cycle the timeout would expire: the byte wins and the counter clears.
- Reset mid-frame: return to IDLE next cycle with no further writes. Words already written stay in memory. cpu_reset=1.

## Configuration
- LOADER_CHECKSUM_EN defined: CHECK state present. A trailing XOR-of-all-data-bytes checksum byte is required, and a mismatch gives ERROR.
- Not defined: no checksum byte, no accumulator, no CHECK state. The last data byte's write is followed by DONE; the next cycle's state is DONE.

## Test plan
- Macro on; send A5 02 11 22 33 44 55 66 77 88 88 -> two writes: 0x00←0x11223344, then 0x01←0x55667788. Then load_done=1, cpu_reset=0, word_count=2.
- Same frame with checksum 0x00 -> both writes occur, then load_error=1, load_done=0, cpu_reset stays 1.
- TIMEOUT_CYCLES=16; send A5 02 11 then idle 16 cycles -> ERROR, load_error=1, no imem_wren. Then send a valid frame -> load_done=1, load_error=0.
- LEN=00 with 1024 data bytes (word i = {i,i,i,i}) and correct checksum -> 256 writes, last at 0xFF with data 0xFFFFFFFF, word_count=256, imem_address=0x00.
- Apply reset after A5 01 DE AD -> no write, state IDLE, cpu_reset=1. Then send A5 01 CA FE BA BE 30 -> 0x00←0xCAFEBABE, load_done=1.
- Garbage 00 FF 5A in IDLE -> ignored. After a loaded image, send A5 -> cpu_reset=1 and load_done=0 on the next cycle.
